// File: rtl/jtpopeye_dwnld.sv
// jtpopeye_dwnld
// ROM download adapter. Bytes from the MiST ioctl stream are steered to the
// SDRAM programming port (16-bit word with a byte-lane mask), to one of four
// on-chip colour PROM write strobes, or to the Sky Skipper config latch.
// A single-entry skid buffer holds one SDRAM byte that arrives while the
// previous SDRAM write is still waiting to be accepted.

module jtpopeye_dwnld #(
   parameter logic [21:0] SDRAM_END = 22'h1A000,
   parameter logic [21:0] CFG_ADDR  = SDRAM_END + 22'h400
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        downloading,
   input  logic [21:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        ioctl_wr,
   input  logic        prog_rdy,
   output logic [21:0] prog_addr,
   output logic [7:0]  prog_data,
   output logic [1:0]  prog_mask,
   output logic        prog_we,
   output logic [3:0]  prom_we,
   output logic [7:0]  prom_addr,
   output logic [7:0]  prom_data,
   output logic        skyskipper,
   output logic        dwnld_busy,
   output logic        overflow,
   output logic [15:0] checksum
);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t      state;

   logic        byte_wr;
   logic        is_sdram;
   logic        is_prom;
   logic        is_cfg;
   logic        sdram_wr;
   logic        prom_wr;
   logic        cfg_wr;
   logic [21:0] prom_offset;
   logic [21:0] new_addr;
   logic [1:0]  new_mask;

   logic        dl_last;
   logic        dl_rise;

   logic        skid_valid;
   logic [21:0] skid_addr;
   logic [7:0]  skid_data;
   logic [1:0]  skid_mask;

   // Classify the incoming byte and precompute the SDRAM word fields
   always_comb begin
      byte_wr     = downloading & ioctl_wr;
      prom_offset = ioctl_addr - SDRAM_END;
      is_sdram    = ioctl_addr < SDRAM_END;
      is_prom     = !is_sdram && (prom_offset < 22'd1024);
      is_cfg      = ioctl_addr == CFG_ADDR;
      sdram_wr    = byte_wr & is_sdram;
      prom_wr     = byte_wr & is_prom;
      cfg_wr      = byte_wr & is_cfg;
      new_addr    = {1'b0, ioctl_addr[21:1]};
      new_mask    = ioctl_addr[0] ? 2'b01 : 2'b10;
      dl_rise     = downloading & ~dl_last;
   end

   // Remember the previous download flag so a new download can be detected
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl_last <= 1'b0;
      end else begin
         dl_last <= downloading;
      end
   end

   // SDRAM write handshake with the skid buffer behind the output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         prog_we    <= 1'b0;
         prog_addr  <= 22'd0;
         prog_data  <= 8'd0;
         prog_mask  <= 2'b00;
         skid_valid <= 1'b0;
         skid_addr  <= 22'd0;
         skid_data  <= 8'd0;
         skid_mask  <= 2'b00;
         overflow   <= 1'b0;
      end else begin
         if (dl_rise) begin
            overflow <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               prog_we <= 1'b0;
               if (sdram_wr) begin
                  prog_addr <= new_addr;
                  prog_data <= ioctl_data;
                  prog_mask <= new_mask;
                  prog_we   <= 1'b1;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (prog_rdy) begin
                  if (skid_valid) begin
                     prog_addr <= skid_addr;
                     prog_data <= skid_data;
                     prog_mask <= skid_mask;
                     if (sdram_wr) begin
                        skid_addr <= new_addr;
                        skid_data <= ioctl_data;
                        skid_mask <= new_mask;
                     end else begin
                        skid_valid <= 1'b0;
                     end
                  end else if (sdram_wr) begin
                     prog_addr <= new_addr;
                     prog_data <= ioctl_data;
                     prog_mask <= new_mask;
                  end else begin
                     prog_we <= 1'b0;
                     state   <= ST_IDLE;
                  end
               end else if (sdram_wr) begin
                  if (skid_valid) begin
                     overflow <= 1'b1;
                  end else begin
                     skid_valid <= 1'b1;
                     skid_addr  <= new_addr;
                     skid_data  <= ioctl_data;
                     skid_mask  <= new_mask;
                  end
               end
            end
            default: begin
               prog_we <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   // One-cycle PROM write strobe with its address and data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prom_we   <= 4'd0;
         prom_addr <= 8'd0;
         prom_data <= 8'd0;
      end else begin
         prom_we <= 4'd0;
         if (prom_wr) begin
            prom_we   <= 4'b0001 << prom_offset[9:8];
            prom_addr <= prom_offset[7:0];
            prom_data <= ioctl_data;
         end
      end
   end

   // Sky Skipper config latch, cleared at the start of each download
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skyskipper <= 1'b0;
      end else begin
         if (dl_rise) begin
            skyskipper <= 1'b0;
         end
         if (cfg_wr) begin
            skyskipper <= ioctl_data[0];
         end
      end
   end

   // Running 16-bit sum of every accepted byte, restarted per download
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= 16'd0;
      end else if (dl_rise) begin
         checksum <= byte_wr ? {8'd0, ioctl_data} : 16'd0;
      end else if (byte_wr) begin
         checksum <= checksum + {8'd0, ioctl_data};
      end
   end

   // Busy while downloading or while any SDRAM write is still outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwnld_busy <= 1'b0;
      end else begin
         dwnld_busy <= downloading | prog_we | skid_valid;
      end
   end

endmodule

// File: doc/jtpopeye_dwnld.md
# jtpopeye_dwnld

ROM download adapter between the MiST ioctl byte stream and the SDRAM programming port plus on-chip colour PROMs. It routes each downloaded byte either to a 16-bit SDRAM write with a byte-lane mask, or to one of four internal PROM write strobes, or to the Sky Skipper config latch. It sits upstream of the SDRAM loader inside the frame and feeds `skyskipper` and the PROM contents to the game. A one-entry skid buffer absorbs ioctl writes that arrive while an SDRAM write is still waiting for acceptance.

## Interface
- `SDRAM_END`, default 22'h1A000: first download address not stored in SDRAM.
- `CFG_ADDR`, default `SDRAM_END`+22'h400: address of the Sky Skipper config byte.
- `clk` in 1: system clock, 40 MHz.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `downloading` in 1: download window active.
- `ioctl_addr` in 22: byte address.
- `ioctl_data` in 8: byte data.
- `ioctl_wr` in 1: one-cycle byte strobe. Ignored when `downloading`=0.
- `prog_rdy` in 1: SDRAM write accepted this cycle.
- `prog_addr` out 22: word address.
- `prog_data` out 8: byte data, replicated on both lanes by the SDRAM side.
- `prog_mask` out 2: per-lane mask; 1 = lane masked.
- `prog_we` out 1: write request, held until accepted.
- `prom_we` out 4: one-hot PROM write pulse.
- `prom_addr` out 8: PROM address.
- `prom_data` out 8: PROM data.
- `skyskipper` out 1: config latch.
- `dwnld_busy` out 1: download or pending write in progress.
- `overflow` out 1: sticky; a byte was lost.
- `checksum` out 16: modular sum of all accepted bytes.

## Operation
- Byte classification, with A = `ioctl_addr`:
  - A < `SDRAM_END`: SDRAM byte.
  - `SDRAM_END` ≤ A < `SDRAM_END`+1024: PROM byte. Offset O = A−`SDRAM_END`; PROM index = O[9:8]; `prom_addr` = O[7:0].
  - A = `CFG_ADDR`: `skyskipper` ← data[0].
  - Any other address: ignored, but still counted in `checksum`.
- SDRAM write fields:
  - `prog_addr` = {1'b0, A[21:1]}.
  - `prog_data` = byte.
  - `prog_mask` = 2'b10 when A[0]=0, 2'b01 when A[0]=1.
- States:
  - IDLE: `prog_we`=0. An SDRAM byte moves to WAIT.
  - WAIT: `prog_we`=1 with stable fields.
    - On `prog_rdy`: if the buffer is valid, load the buffer into the outputs and stay in WAIT; otherwise go to IDLE.
    - An SDRAM byte arriving in WAIT goes into the buffer.
    - If the buffer is already full and `prog_rdy`=0, drop the byte and set `overflow`.
    - If `ioctl_wr` and `prog_rdy` coincide while the buffer is full, the buffer moves to the outputs and the new byte enters the buffer; no overflow.
- PROM and config bytes never touch the FSM or buffer. They are handled the cycle after `ioctl_wr`, whatever the FSM state.
- Rising edge of `downloading`: clears `checksum`, `overflow`, `skyskipper`.
- Falling edge of `downloading`: pending SDRAM writes still complete.
- `dwnld_busy` = `downloading` | `prog_we` | buffer valid.
- `checksum` += byte on every accepted `ioctl_wr`. Width is 16 bits and wraps.

## Timing
- Reset values: all outputs 0; FSM in IDLE; buffer empty. Reset mid-download abandons pending writes immediately.
- `ioctl_wr` at cycle N:
  - SDRAM byte with FSM in IDLE: `prog_we` rises at N+1.
  - PROM byte: `prom_we` pulses exactly at N+1, with `prom_addr`/`prom_data` valid the same cycle.
  - Config byte: `skyskipper` updates at N+1.
- `prog_rdy` sampled high at cycle M:
  - Buffer empty: `prog_we` low at M+1.
  - Buffer valid: `prog_we` stays high at M+1 with the buffered fields.
- Output fields never change while `prog_we`=1 and `prog_rdy`=0.
- `prog_rdy` while `prog_we`=0 is ignored.
- `checksum` and `dwnld_busy` are registered, with one-cycle latency.

## Test plan
- Basic SDRAM write: `downloading`=1, write A=0x00005, D=0xA5, hold `prog_rdy`=0 for 3 cycles then 1. Expect `prog_addr`=0x00002, `prog_mask`=2'b01, `prog_we` high 4 cycles then low; `checksum`=0x00A5.
- Skid buffer: writes A=0x10, 0x11, 0x12 on consecutive cycles, `prog_rdy`=0 throughout. Expect `overflow`=1 after the third write; outputs still show A=0x10's fields. Then pulse `prog_rdy` twice. Expect outputs step to A=0x11's word (0x08) with mask 2'b01, then `prog_we`=0; `dwnld_busy` drops once `downloading` falls.
- Simultaneous accept and write: buffer full, then `ioctl_wr` and `prog_rdy` in the same cycle. Expect no overflow and three total writes issued in order.
- PROM routing: A=0x1A2C3, D=0x3C. Expect `prom_we`=4'b0100 for 1 cycle, `prom_addr`=0xC3, `prog_we` stays 0.
- Config latch: A=0x1A400, D=0x01. Expect `skyskipper`=1. Raise `downloading` again: expect `skyskipper`, `overflow` and `checksum` cleared.
- Reset mid-write: assert `rst_n`=0 while `prog_we`=1 with the buffer valid. Expect all outputs 0 asynchronously; after release the FSM is in IDLE and no write is issued.
